rx_frame_ctrl: RTL and testbench
================================

Name: rx_frame_ctrl

Overview:
Controller that sequences the serial frame receiver: programs its baud divisor, arms it, supervises each frame with a watchdog, and classifies the result from the noise, CRC and framing flags. Good frames go into a one-entry output buffer with a valid/ready handshake to the consumer. Bad frames are dropped and counted. Sits between the receiver and the packet consumer.

Parameters:
DEFAULT_BAUD, 8'd16, baud divisor loaded at reset
TO_W, 16, watchdog counter width
CNT_W, 8, width of the saturating statistics counters

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
cfg_baud  in  8  new baud divisor
cfg_baud_we  in  1  write strobe for cfg_baud
cfg_timeout  in  TO_W  watchdog limit in clk cycles; 0 disables the watchdog
baudrate  out  8  divisor driven to the receiver
rx_arm  out  1  one-cycle pulse that resets the receiver to its start state and clears its CRC
rx_busy  in  1  receiver has left its start state
rx_done  in  1  one-cycle pulse when the stop bit has been sampled
rx_framesize  in  4  payload byte count
rx_framedata  in  128  payload, byte 0 in [127:120]
rx_nf, rx_crce, rx_fe  in  1 each  noise, CRC and framing error flags, valid with rx_done
out_valid  out  1  output buffer full
out_ready  in  1  consumer accepts
out_data  out  128  buffered payload
out_len  out  4  buffered byte count
ok_cnt, err_cnt  out  CNT_W each  frames accepted / frames dropped
ovf  out  1  sticky overrun flag
last_status  out  4  {timeout, nf, crce, fe} of the last completed or aborted frame

Behaviour:
- Reset values: baudrate=DEFAULT_BAUD; every other output 0; state=ARM.
- Baud register: cfg_baud_we writes a pending register in any state. The pending value is copied to baudrate only in ARM, so the divisor never changes mid-frame.
- FSM:
  - ARM: drive rx_arm=1 for exactly one cycle, load baudrate from the pending register, clear the watchdog, then go to WAIT.
  - WAIT: rx_busy=1 -> RUN (watchdog restarts at 0).
  - RUN: watchdog increments every cycle. rx_done -> CHECK. If cfg_timeout!=0 and watchdog==cfg_timeout-1 with no rx_done: last_status=4'b1000, err_cnt+1, go to ARM. If rx_done and the timeout occur in the same cycle, rx_done wins.
  - CHECK (one cycle): latch the flags into last_status[2:0] and clear bit 3.
    - Any flag set, or rx_framesize==0: err_cnt+1, drop the frame.
    - Otherwise, if out_valid==0 or out_ready==1 this cycle: load out_data/out_len from the receiver, set out_valid, ok_cnt+1.
    - Otherwise (buffer full and not draining): set ovf, err_cnt+1, drop the frame.
    - Next state is always ARM.
- Latency: frame accepted in CHECK -> out_valid high the next cycle. rx_done -> rx_arm takes 2 cycles.
- Handshake: out_data and out_len are stable while out_valid && !out_ready. A transfer occurs on out_valid && out_ready, which clears out_valid unless CHECK reloads the buffer in the same cycle. A same-cycle pop and load leaves out_valid=1 with the new data.
- Counters saturate at all-ones and never wrap. ovf is cleared only by reset.
- rx_done outside RUN is ignored.
- Reset asserted mid-frame: all state is cleared immediately. After release, the first cycle is ARM, so the receiver is re-armed.

Test Plan:
1. Reset, release -> baudrate=16, rx_arm high for one cycle, FSM in WAIT. Feed rx_busy, then rx_done with framesize=2, data=0xA55A<<112, flags 0 -> out_valid=1, out_len=2, ok_cnt=1, rx_arm pulses again 2 cycles after rx_done.
2. rx_done with rx_crce=1 -> out_valid stays 0, err_cnt=1, last_status=4'b0010. Repeat with rx_nf=1 -> last_status=4'b0100, err_cnt=2.
3. cfg_timeout=50, rx_busy asserted, no rx_done -> 50 cycles later last_status=4'b1000, err_cnt+1, rx_arm pulses. Repeat with cfg_timeout=0 -> no abort after 1000 cycles.
4. out_ready held 0, two good frames -> first frame's data stays stable, second dropped, ovf=1, ok_cnt=1, err_cnt=1. Then raise out_ready in the same cycle as a third frame's CHECK -> out_valid stays 1 with the third frame's data.
5. Write cfg_baud=8'd40 during RUN -> baudrate stays 16 until the next ARM, then reads 40.
6. Force 300 errored frames -> err_cnt saturates at 255. Assert reset_n=0 mid-RUN -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/rx_frame_ctrl.sv
// rtl/rx_frame_ctrl.sv - serial frame receiver sequencer with watchdog, classification and one-entry output buffer
module rx_frame_ctrl #(
    parameter logic [7:0] DEFAULT_BAUD = 8'd16,
    parameter int         TO_W         = 16,
    parameter int         CNT_W        = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [7:0]       cfg_baud,
    input  logic             cfg_baud_we,
    input  logic [TO_W-1:0]  cfg_timeout,
    output logic [7:0]       baudrate,
    output logic             rx_arm,
    input  logic             rx_busy,
    input  logic             rx_done,
    input  logic [3:0]       rx_framesize,
    input  logic [127:0]     rx_framedata,
    input  logic             rx_nf,
    input  logic             rx_crce,
    input  logic             rx_fe,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     out_data,
    output logic [3:0]       out_len,
    output logic [CNT_W-1:0] ok_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             ovf,
    output logic [3:0]       last_status
);

    typedef enum logic [1:0] {S_ARM, S_WAIT, S_RUN, S_CHECK} state_t;

    state_t            state, state_nxt;
    logic [7:0]        baud_pend;
    logic [TO_W-1:0]   wd;
    logic [2:0]        flags_q;
    logic [3:0]        size_q;
    logic [127:0]      data_q;

    logic timeout_hit;
    logic abort;
    logic frame_bad;
    logic can_load;
    logic accept;
    logic overrun;
    logic err_inc;

    assign timeout_hit = (cfg_timeout != '0) && (wd == cfg_timeout - TO_W'(1));

    // Gated by reset_n so the arm pulse stays low while reset holds the FSM in ARM.
    assign rx_arm = (state == S_ARM) && reset_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_ARM;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        abort     = 1'b0;
        frame_bad = (flags_q != 3'b000) || (size_q == 4'd0);
        can_load  = !out_valid || out_ready;
        accept    = 1'b0;
        overrun   = 1'b0;
        case (state)
            S_ARM:   state_nxt = S_WAIT;
            S_WAIT:  if (rx_busy) state_nxt = S_RUN;
            S_RUN: begin
                if (rx_done) begin
                    state_nxt = S_CHECK;
                end else if (timeout_hit) begin
                    abort     = 1'b1;
                    state_nxt = S_ARM;
                end
            end
            S_CHECK: begin
                accept    = !frame_bad && can_load;
                overrun   = !frame_bad && !can_load;
                state_nxt = S_ARM;
            end
            default: state_nxt = S_ARM;
        endcase
        err_inc = abort || ((state == S_CHECK) && !accept);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            baud_pend   <= DEFAULT_BAUD;
            baudrate    <= DEFAULT_BAUD;
            wd          <= '0;
            flags_q     <= '0;
            size_q      <= '0;
            data_q      <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_len     <= '0;
            ok_cnt      <= '0;
            err_cnt     <= '0;
            ovf         <= 1'b0;
            last_status <= '0;
        end else begin
            if (cfg_baud_we) baud_pend <= cfg_baud;
            if (state == S_ARM) baudrate <= baud_pend;

            if (state == S_RUN) begin
                wd <= wd + TO_W'(1);
            end else begin
                wd <= '0;
            end

            // Receiver outputs are only guaranteed alongside rx_done, so capture them for CHECK.
            if (state == S_RUN && rx_done) begin
                flags_q <= {rx_nf, rx_crce, rx_fe};
                size_q  <= rx_framesize;
                data_q  <= rx_framedata;
            end

            if (abort) begin
                last_status <= 4'b1000;
            end else if (state == S_CHECK) begin
                last_status <= {1'b0, flags_q};
            end

            if (accept) begin
                out_valid <= 1'b1;
                out_data  <= data_q;
                out_len   <= size_q;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            if (accept && ok_cnt != '1) ok_cnt <= ok_cnt + CNT_W'(1);
            if (err_inc && err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
            if (overrun) ovf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// tb/tb_rx_frame_ctrl.sv - directed table-driven bench for rx_frame_ctrl
module tb_rx_frame_ctrl;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [7:0]   cfg_baud;
    logic         cfg_baud_we;
    logic [15:0]  cfg_timeout;
    logic [7:0]   baudrate;
    logic         rx_arm;
    logic         rx_busy;
    logic         rx_done;
    logic [3:0]   rx_framesize;
    logic [127:0] rx_framedata;
    logic         rx_nf, rx_crce, rx_fe;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic [3:0]   out_len;
    logic [7:0]   ok_cnt, err_cnt;
    logic         ovf;
    logic [3:0]   last_status;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rx_frame_ctrl dut (
        .clk(clk), .reset_n(reset_n),
        .cfg_baud(cfg_baud), .cfg_baud_we(cfg_baud_we), .cfg_timeout(cfg_timeout),
        .baudrate(baudrate), .rx_arm(rx_arm), .rx_busy(rx_busy), .rx_done(rx_done),
        .rx_framesize(rx_framesize), .rx_framedata(rx_framedata),
        .rx_nf(rx_nf), .rx_crce(rx_crce), .rx_fe(rx_fe),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_len(out_len),
        .ok_cnt(ok_cnt), .err_cnt(err_cnt), .ovf(ovf), .last_status(last_status)
    );

    typedef struct {
        logic [3:0]   size;
        logic [127:0] data;
        logic [2:0]   flg;
        logic         rdy;
        logic         e_valid;
        logic [3:0]   e_len;
        logic [127:0] e_data;
        logic [7:0]   e_ok;
        logic [7:0]   e_err;
        logic         e_ovf;
        logic [3:0]   e_status;
    } vec_t;

    vec_t vec [9];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Starts in WAIT at a negedge, ends at the negedge of the following ARM cycle.
    task automatic run_frame(input logic [3:0] size, input logic [127:0] data,
                             input logic [2:0] flg, input logic rdy);
        rx_busy = 1'b1;
        @(negedge clk);
        rx_busy = 1'b0;
        rx_done = 1'b1;
        rx_framesize = size;
        rx_framedata = data;
        {rx_nf, rx_crce, rx_fe} = flg;
        @(negedge clk);
        rx_done = 1'b0;
        {rx_nf, rx_crce, rx_fe} = 3'b000;
        out_ready = rdy;
        @(negedge clk);
    endtask

    task automatic to_wait();
        out_ready = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int arm_seen;
        vec[0] = '{4'd2, {16'hA55A, 112'h0}, 3'b000, 1'b0, 1'b1, 4'd2, {16'hA55A, 112'h0}, 8'd1, 8'd0, 1'b0, 4'b0000};
        vec[1] = '{4'd1, {8'h77, 120'h0},    3'b010, 1'b1, 1'b0, 4'd0, 128'h0,              8'd1, 8'd1, 1'b0, 4'b0010};
        vec[2] = '{4'd1, {8'h66, 120'h0},    3'b100, 1'b0, 1'b0, 4'd0, 128'h0,              8'd1, 8'd2, 1'b0, 4'b0100};
        vec[3] = '{4'd1, {8'h55, 120'h0},    3'b001, 1'b0, 1'b0, 4'd0, 128'h0,              8'd1, 8'd3, 1'b0, 4'b0001};
        vec[4] = '{4'd0, {8'h44, 120'h0},    3'b000, 1'b0, 1'b0, 4'd0, 128'h0,              8'd1, 8'd4, 1'b0, 4'b0000};
        vec[5] = '{4'd3, {8{16'h1111}},      3'b000, 1'b0, 1'b1, 4'd3, {8{16'h1111}},       8'd2, 8'd4, 1'b0, 4'b0000};
        vec[6] = '{4'd4, {8{16'h2222}},      3'b000, 1'b0, 1'b1, 4'd3, {8{16'h1111}},       8'd2, 8'd5, 1'b1, 4'b0000};
        vec[7] = '{4'd5, {8{16'h3333}},      3'b000, 1'b1, 1'b1, 4'd5, {8{16'h3333}},       8'd3, 8'd5, 1'b1, 4'b0000};
        vec[8] = '{4'd6, {8{16'h4444}},      3'b111, 1'b1, 1'b0, 4'd0, 128'h0,              8'd3, 8'd6, 1'b1, 4'b0111};

        reset_n = 1'b0;
        cfg_baud = 8'd0; cfg_baud_we = 1'b0; cfg_timeout = 16'd0;
        rx_busy = 1'b0; rx_done = 1'b0; rx_framesize = 4'd0; rx_framedata = 128'h0;
        rx_nf = 1'b0; rx_crce = 1'b0; rx_fe = 1'b0; out_ready = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_baud", 128'(baudrate), 128'd16);
        chk("rst_arm", 128'(rx_arm), 128'd0);
        chk("rst_valid", 128'(out_valid), 128'd0);
        chk("rst_cnts", {ok_cnt, err_cnt, ovf, last_status}, 128'd0);
        reset_n = 1'b1;
        #1 chk("arm_after_release", 128'(rx_arm), 128'd1);
        @(negedge clk);
        chk("arm_one_cycle", 128'(rx_arm), 128'd0);

        for (int i = 0; i < 9; i++) begin
            run_frame(vec[i].size, vec[i].data, vec[i].flg, vec[i].rdy);
            chk($sformatf("v%0d_arm", i), 128'(rx_arm), 128'd1);
            chk($sformatf("v%0d_valid", i), 128'(out_valid), 128'(vec[i].e_valid));
            if (vec[i].e_valid) begin
                chk($sformatf("v%0d_len", i), 128'(out_len), 128'(vec[i].e_len));
                chk($sformatf("v%0d_data", i), out_data, vec[i].e_data);
            end
            chk($sformatf("v%0d_ok", i), 128'(ok_cnt), 128'(vec[i].e_ok));
            chk($sformatf("v%0d_err", i), 128'(err_cnt), 128'(vec[i].e_err));
            chk($sformatf("v%0d_ovf", i), 128'(ovf), 128'(vec[i].e_ovf));
            chk($sformatf("v%0d_status", i), 128'(last_status), 128'(vec[i].e_status));
            to_wait();
        end

        // rx_done while in WAIT must be ignored
        rx_done = 1'b1; rx_framesize = 4'd2; rx_framedata = {8{16'h5555}};
        @(negedge clk);
        rx_done = 1'b0;
        repeat (2) @(negedge clk);
        chk("ign_ok", 128'(ok_cnt), 128'd3);
        chk("ign_valid", 128'(out_valid), 128'd0);
        chk("ign_arm", 128'(rx_arm), 128'd0);

        // watchdog: 50 RUN cycles then abort
        cfg_timeout = 16'd50;
        rx_busy = 1'b1;
        @(negedge clk);
        rx_busy = 1'b0;
        repeat (49) @(negedge clk);
        chk("to_not_yet", 128'(rx_arm), 128'd0);
        @(negedge clk);
        chk("to_arm", 128'(rx_arm), 128'd1);
        chk("to_status", 128'(last_status), 128'b1000);
        chk("to_err", 128'(err_cnt), 128'd7);
        @(negedge clk);

        // watchdog disabled
        cfg_timeout = 16'd0;
        rx_busy = 1'b1;
        @(negedge clk);
        rx_busy = 1'b0;
        arm_seen = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (rx_arm) arm_seen++;
        end
        chk("noto_arm", 128'(arm_seen), 128'd0);
        chk("noto_err", 128'(err_cnt), 128'd7);
        rx_done = 1'b1; rx_fe = 1'b1;
        @(negedge clk);
        rx_done = 1'b0; rx_fe = 1'b0;
        @(negedge clk);
        chk("noto_end_err", 128'(err_cnt), 128'd8);
        chk("noto_end_status", 128'(last_status), 128'b0001);
        @(negedge clk);

        // baud write mid-frame only takes effect in ARM
        rx_busy = 1'b1;
        @(negedge clk);
        rx_busy = 1'b0;
        cfg_baud = 8'd40; cfg_baud_we = 1'b1;
        @(negedge clk);
        cfg_baud_we = 1'b0;
        chk("baud_run", 128'(baudrate), 128'd16);
        rx_done = 1'b1; rx_fe = 1'b1;
        @(negedge clk);
        rx_done = 1'b0; rx_fe = 1'b0;
        @(negedge clk);
        chk("baud_arm", 128'(baudrate), 128'd16);
        @(negedge clk);
        chk("baud_new", 128'(baudrate), 128'd40);

        // saturation of err_cnt (9 + 300 > 255)
        for (int i = 0; i < 300; i++) begin
            run_frame(4'd1, 128'h0, 3'b001, 1'b0);
            to_wait();
        end
        chk("sat_err", 128'(err_cnt), 128'd255);
        chk("sat_ok", 128'(ok_cnt), 128'd3);

        // asynchronous reset mid-RUN
        rx_busy = 1'b1;
        @(negedge clk);
        rx_busy = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_baud", 128'(baudrate), 128'd16);
        chk("mid_rst_arm", 128'(rx_arm), 128'd0);
        chk("mid_rst_cnts", {ok_cnt, err_cnt, ovf, last_status}, 128'd0);
        chk("mid_rst_buf", {out_valid, out_len}, 128'd0);
        chk("mid_rst_data", out_data, 128'd0);
        @(negedge clk);
        reset_n = 1'b1;
        #1 chk("rearm_after_rst", 128'(rx_arm), 128'd1);
        @(negedge clk);
        chk("rearm_baud", 128'(baudrate), 128'd16);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
